// File: rtl/etcpu_data_mem.sv
// Word-organised data RAM on the etcpu memory interface: zero-fill sweep after reset, sticky address error.
// Optional per-word even parity with a sticky par_err, enabled by defining ETCPU_DATA_MEM_PAR_EN.
module etcpu_data_mem #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_cs,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dat_in,
  output logic [31:0] mem_dat_out,
  output logic        mem_rdy,
  output logic        addr_err,
  output logic        par_err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
`ifdef ETCPU_DATA_MEM_PAR_EN
  localparam int WORD_W = 33;
`else
  localparam int WORD_W = 32;
`endif

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state_q;
  logic [DEPTH_LOG2-1:0]   init_cnt_q;
  logic                    rdy_q;
  logic                    addr_err_q;
  logic [WORD_W-1:0]       mem_q [0:DEPTH-1];

  logic [DEPTH_LOG2-1:0]   idx;
  logic                    in_range;
  logic                    aligned;
  logic                    run_acc;
  logic                    store_en;
  logic                    load_en;
  logic [WORD_W-1:0]       rd_word;
  logic [WORD_W-1:0]       wr_word;

  assign idx      = mem_addr[DEPTH_LOG2+1:2];
  assign in_range = (mem_addr[31:DEPTH_LOG2+2] == '0);
  assign aligned  = (mem_addr[1:0] == 2'b00);
  assign run_acc  = (state_q == RUN) && mem_cs;
  assign store_en = run_acc && mem_wen && in_range;
  assign load_en  = run_acc && !mem_wen && in_range;
  assign rd_word  = mem_q[idx];

`ifdef ETCPU_DATA_MEM_PAR_EN
  assign wr_word  = {^mem_dat_in, mem_dat_in};
`else
  assign wr_word  = mem_dat_in;
`endif

  // Loads are combinational; anything other than an in-range RUN load reads as zero.
  assign mem_dat_out = load_en ? rd_word[31:0] : 32'h0;
  assign mem_rdy     = rdy_q;
  assign addr_err    = addr_err_q;

`ifdef ETCPU_DATA_MEM_PAR_EN
  logic par_err_q;
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      rdy_q      <= 1'b0;
      addr_err_q <= 1'b0;
`ifdef ETCPU_DATA_MEM_PAR_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == DEPTH_LOG2'(DEPTH - 1)) begin
            state_q <= RUN;
            rdy_q   <= 1'b1;
          end
        end
        RUN: begin
          if (run_acc && (!in_range || !aligned))
            addr_err_q <= 1'b1;
`ifdef ETCPU_DATA_MEM_PAR_EN
          if (load_en && (^rd_word != 1'b0))
            par_err_q <= 1'b1;
`endif
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // The array has no reset; the INIT sweep clears it, and a store on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == INIT)
        mem_q[init_cnt_q] <= '0;
      else if (store_en)
        mem_q[idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_etcpu_data_mem.sv
// Randomised and directed bench for etcpu_data_mem (DEPTH_LOG2=4) against a word-array reference model.
module tb_etcpu_data_mem;

  localparam int DL2   = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_cs = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_dat_in = '0;
  logic [31:0] mem_dat_out;
  logic        mem_rdy;
  logic        addr_err;
  logic        par_err;

  etcpu_data_mem #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst_n(rst_n), .mem_cs(mem_cs), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_dat_in(mem_dat_in), .mem_dat_out(mem_dat_out),
    .mem_rdy(mem_rdy), .addr_err(addr_err), .par_err(par_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs follow from the edges counted since reset release
  // and a plain word array; the zero sweep is modelled as clearing the array on reset.
  logic [31:0] m_mem [DEPTH];
  logic        m_bad [DEPTH];
  int          m_edges;
  logic        m_rdy, m_aerr, m_perr;
  logic        started = 1'b0;

  function automatic logic addr_ok(input logic [31:0] a);
    return a[31:DL2+2] == '0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      started = 1'b1;
      m_edges = 0;
      m_rdy   = 1'b0;
      m_aerr  = 1'b0;
      m_perr  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = '0;
        m_bad[i] = 1'b0;
      end
    end else if (!m_rdy) begin
      m_edges++;
      if (m_edges == DEPTH) m_rdy = 1'b1;
    end else if (mem_cs) begin
      if (!addr_ok(mem_addr) || mem_addr[1:0] != 2'b00) m_aerr = 1'b1;
      if (addr_ok(mem_addr)) begin
        if (mem_wen) begin
          m_mem[mem_addr[DL2+1:2]] = mem_dat_in;
          m_bad[mem_addr[DL2+1:2]] = 1'b0;
        end else begin
`ifdef ETCPU_DATA_MEM_PAR_EN
          if (m_bad[mem_addr[DL2+1:2]]) m_perr = 1'b1;
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("dat_out", mem_dat_out,
            (m_rdy && mem_cs && !mem_wen && addr_ok(mem_addr)) ? m_mem[mem_addr[DL2+1:2]] : 32'h0);
      check("mem_rdy", {31'h0, mem_rdy}, {31'h0, m_rdy});
      check("addr_err", {31'h0, addr_err}, {31'h0, m_aerr});
      check("par_err", {31'h0, par_err}, {31'h0, m_perr});
    end
  end

  task automatic drive(input logic cs, input logic wen, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    mem_cs = cs; mem_wen = wen; mem_addr = a; mem_dat_in = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Hold reset, release it, and confirm mem_rdy rises on exactly the DEPTH-th edge.
  task automatic reset_and_sweep(input int hold);
    @(posedge clk); #1;
    rst_n = 1'b0; mem_cs = 1'b0; mem_wen = 1'b0;
    repeat (hold) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_rdy", {31'h0, mem_rdy}, 32'h0);
    check("rst_aerr", {31'h0, addr_err}, 32'h0);
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clk); #1;
      if (k == DEPTH - 1) check("rdy_before", {31'h0, mem_rdy}, 32'h0);
      if (k == DEPTH)     check("rdy_after", {31'h0, mem_rdy}, 32'h1);
    end
  endtask

  initial begin
    // T1: init sweep and zeroed array
    reset_and_sweep(3);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 32'(i * 4), 32'h0);
      #1 check("init_zero", mem_dat_out, 32'h0);
    end

    // T2: stores and loads, store-then-load forwarding across cycles
    drive(1'b1, 1'b1, 32'h8, 32'hDEADBEEF);
    drive(1'b1, 1'b1, 32'hC, 32'h12345678);
    drive(1'b1, 1'b0, 32'h8, 32'h0);
    #1 check("ld_8", mem_dat_out, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 32'hC, 32'h0);
    #1 check("ld_C", mem_dat_out, 32'h12345678);
    drive(1'b1, 1'b1, 32'h8, 32'hCAFEF00D);
    drive(1'b1, 1'b0, 32'h8, 32'h0);
    #1 check("ld_8_new", mem_dat_out, 32'hCAFEF00D);
    drive(1'b0, 1'b1, 32'h8, 32'h0);
    #1 check("cs0_zero", mem_dat_out, 32'h0);
    check("no_aerr", {31'h0, addr_err}, 32'h0);

    // T3: out-of-range store is dropped and flagged
    drive(1'b1, 1'b1, 32'h40, 32'hAAAA5555);
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    #1 check("oor_no_write", mem_dat_out, 32'h0);
    check("oor_aerr", {31'h0, addr_err}, 32'h1);
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    #1 check("oor_load", mem_dat_out, 32'h0);
    repeat (3) idle();
    check("aerr_sticky", {31'h0, addr_err}, 32'h1);

    // T4: misaligned store lands on the word, flagged
    reset_and_sweep(2);
    drive(1'b1, 1'b1, 32'h6, 32'h11111111);
    drive(1'b1, 1'b0, 32'h4, 32'h0);
    #1 check("mis_word", mem_dat_out, 32'h11111111);
    check("mis_aerr", {31'h0, addr_err}, 32'h1);

    // T5: reset again in the middle of a sweep; a store during INIT is ignored
    @(posedge clk); #1;
    rst_n = 1'b0; mem_cs = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 5) begin
        mem_cs = 1'b1; mem_wen = 1'b1; mem_addr = 32'h0; mem_dat_in = 32'hFFFFFFFF;
      end else begin
        mem_cs = 1'b0;
      end
      if (c == 8) rst_n = 1'b0;
    end
    check("t5_rdy_low", {31'h0, mem_rdy}, 32'h0);
    reset_and_sweep(1);
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    #1 check("t5_word0", mem_dat_out, 32'h0);

    // T6: parity corruption via hierarchical deposit
    drive(1'b1, 1'b1, 32'h4, 32'h00000001);
    idle();
`ifdef ETCPU_DATA_MEM_PAR_EN
    dut.mem_q[1][0] = 1'b0;
    m_mem[1][0] = 1'b0;
    m_bad[1]    = 1'b1;
    drive(1'b1, 1'b0, 32'h4, 32'h0);
    #1 check("par_dat", mem_dat_out, 32'h0);
    idle();
    check("par_err", {31'h0, par_err}, 32'h1);
`else
    drive(1'b1, 1'b0, 32'h4, 32'h0);
    #1 check("par_dat", mem_dat_out, 32'h1);
    idle();
    check("par_err0", {31'h0, par_err}, 32'h0);
`endif

    // Random traffic, mostly in-range and aligned, checked every cycle by the model
    reset_and_sweep(2);
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      if (sel == 0) a = $urandom;
      else if (sel == 1) a[1:0] = 2'($urandom_range(1, 3));
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, $urandom);
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
